// File: rtl/regfile_dump_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_streamer
//  Purpose  : After the core halts, this block reads the architectural register
//             file one register at a time through a combinational read port.
//             It decodes each word as an IEEE-754 single-precision value and
//             emits one record per register on a valid/ready stream.
//  Ports    : clk        - clock; all logic uses the rising edge
//             rst_b      - synchronous, active-high reset
//             halted     - core-halted level; a rising edge starts a scan
//             rs_num     - register index sent to the register-file read port
//             rs_data    - read data for rs_num, valid in the same cycle
//             out_valid  - record valid
//             out_ready  - sink accepts the record
//             out_idx    - register index of the record
//             out_word   - raw register value
//             out_sign   - out_word[31]
//             out_exp    - out_word[30:23]
//             out_frac   - out_word[22:0]
//             out_class  - 0 zero, 1 subnormal, 2 normal, 3 inf,
//                          4 quiet NaN, 5 signalling NaN
//             busy       - scan in progress
//             done       - scan complete; held until halted drops
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_streamer #(
    parameter int XLEN = 32,
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    output logic [4:0]      rs_num,
    input  logic [XLEN-1:0] rs_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic [XLEN-1:0] out_word,
    output logic            out_sign,
    output logic [7:0]      out_exp,
    output logic [22:0]     out_frac,
    output logic [2:0]      out_class,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] c_last_idx   = 5'(SIZE - 1);
    localparam logic [2:0] c_cls_zero   = 3'd0;
    localparam logic [2:0] c_cls_sub    = 3'd1;
    localparam logic [2:0] c_cls_normal = 3'd2;
    localparam logic [2:0] c_cls_inf    = 3'd3;
    localparam logic [2:0] c_cls_qnan   = 3'd4;
    localparam logic [2:0] c_cls_snan   = 3'd5;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_idx;
    logic [4:0]      w_idx_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            w_load;
    logic            r_halted_q;
    logic            r_trig;
    logic [4:0]      r_out_idx;
    logic [XLEN-1:0] r_word;
    logic [2:0]      r_class;
    logic [2:0]      w_class;

    // Classify the word currently on the read port so it can be captured
    // together with the raw value in the ISSUE cycle.
    always_comb begin
        w_class = c_cls_normal;
        if (rs_data[30:23] == 8'h00) begin
            w_class = (rs_data[22:0] == 23'd0) ? c_cls_zero : c_cls_sub;
        end else if (rs_data[30:23] == 8'hFF) begin
            if (rs_data[22:0] == 23'd0) begin
                w_class = c_cls_inf;
            end else if (rs_data[22]) begin
                w_class = c_cls_qnan;
            end else begin
                w_class = c_cls_snan;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_trig) begin
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 5'd1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (!halted) begin
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_idx_nxt   = 5'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The edge detector output is registered. IDLE therefore acts on a
    // clean one-cycle pulse, which sets the two-cycle trigger-to-first-record
    // latency. A pulse that arrives outside IDLE is dropped, so re-triggers
    // during a scan or in DONE are ignored.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state    <= ST_IDLE;
            r_idx      <= 5'd0;
            r_valid    <= 1'b0;
            r_halted_q <= 1'b0;
            r_trig     <= 1'b0;
            r_out_idx  <= 5'd0;
            r_word     <= '0;
            r_class    <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_halted_q <= halted;
            r_trig     <= halted & ~r_halted_q;
            if (w_load) begin
                r_out_idx <= r_idx;
                r_word    <= rs_data;
                r_class   <= w_class;
            end
        end
    end

    assign rs_num    = r_idx;
    assign out_valid = r_valid;
    assign out_idx   = r_out_idx;
    assign out_word  = r_word;
    assign out_sign  = r_word[31];
    assign out_exp   = r_word[30:23];
    assign out_frac  = r_word[22:0];
    assign out_class = r_class;
    assign busy      = (r_state == ST_ISSUE) || (r_state == ST_HOLD);
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Reads the architectural register file out through one of its combinational read ports once the core halts.
- Decodes each 32-bit word as an IEEE-754 single-precision value: sign, exponent, fraction and class.
- Emits one record per register over a valid/ready stream to the trace/dump sink.
- This is the hardware reader for the register file's end-of-run dump. It replaces the per-register float conversion done in simulation with a synthesizable, back-pressured sequencer.

Parameters:
- XLEN, 32, register width. Float decoding is defined only for XLEN=32.
- SIZE, 32, number of registers scanned (indices 0..SIZE-1). SIZE must be ≤ 32.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_b  input  1  reset. One clock; reset is synchronous and active-high.
- halted  input  1  core halted flag, level.
- rs_num  output  5  register index driven to the register-file read port.
- rs_data  input  XLEN  read data for rs_num, combinational, same cycle.
- out_valid  output  1  record valid.
- out_ready  input  1  sink accepts the record.
- out_idx  output  5  register index of the record.
- out_word  output  XLEN  raw register value.
- out_sign  output  1  out_word[31].
- out_exp  output  8  out_word[30:23].
- out_frac  output  23  out_word[22:0].
- out_class  output  3  value class: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 quiet NaN, 5 signalling NaN.
- busy  output  1  scan in progress.
- done  output  1  scan complete.

Behaviour:
- Reset (rst_b=1 at a clk edge):
  - state=IDLE, idx=0, halted_q=0.
  - All outputs 0, including rs_num, out_* fields, busy and done.
  - Reset mid-scan aborts immediately; no partial record remains valid.
- Trigger: rising edge of halted, i.e. halted=1 && halted_q=0. halted_q is a registered copy of halted. A level-high halted out of reset counts as a rising edge.
- rs_num = idx at all times. idx is a registered counter.
- FSM:
  - IDLE: busy=0, done=0. On trigger: idx<=0, go to ISSUE.
  - ISSUE (1 cycle, busy=1):
    - Latch rs_data into out_word and the decoded fields.
    - out_idx<=idx, out_valid<=1, go to HOLD.
  - HOLD (busy=1): all out_* fields are held stable while out_valid=1 && out_ready=0. On out_valid && out_ready:
    - If idx==SIZE-1: out_valid<=0, go to DONE.
    - Otherwise: out_valid<=0, idx<=idx+1, go to ISSUE.
  - DONE: busy=0, done=1. Held while halted=1. When halted=0, go to IDLE, done<=0, idx<=0.
- Throughput and latency:
  - Peak rate is one record per 2 cycles with out_ready tied high.
  - The first out_valid rises 2 cycles after the edge where the trigger is sampled.
  - A full scan with out_ready=1 asserts done 2*SIZE+1 cycles after the trigger edge.
- Classification, with E=out_exp and F=out_frac:
  - E=0, F=0: zero (class 0), either sign.
  - E=0, F≠0: subnormal (class 1).
  - 0<E<255: normal (class 2).
  - E=255, F=0: infinity (class 3).
  - E=255, F[22]=1: quiet NaN (class 4).
  - E=255, F[22]=0, F≠0: signalling NaN (class 5).
- Boundary conditions:
  - halted falls mid-scan: the scan still completes; the block goes DONE→IDLE on the cycle after halted is seen low in DONE.
  - A new rising edge of halted during ISSUE or HOLD is ignored.
  - out_ready asserted outside HOLD has no effect.
  - idx never wraps, because the scan ends at SIZE-1.
  - The block never writes the register file. Register 0 is read like any other register and is expected to be 0.

Test Plan:
- Reset then trigger, sink always ready; regs r[i]=32'h3F800000+i: 32 records in order with out_idx=0..31, r1 has exp=127, frac=1, class 2; done rises exactly 65 cycles after the trigger edge.
- Back-pressure: out_ready low 5 cycles in HOLD for idx 3: out_idx=3 and out_word held stable, no record skipped or duplicated, idx advances only after acceptance.
- Classification: r1=0x80000000 gives sign 1, class 0; r2=0x00000001 gives class 1; r3=0x7F800000 gives class 3; r4=0x7FC00000 gives class 4; r5=0x7F800001 gives class 5; r6=0xC0490FDB gives sign 1, exp 128, class 2.
- halted drops at record 10: scan continues to 31, done pulses for one cycle, then IDLE. Raising halted again restarts at idx 0.
- rst_b asserted in HOLD at idx 17: next cycle out_valid=0, busy=0, rs_num=0, done=0. No record is emitted until a new trigger; with halted still high, a trigger is re-detected and restarts at idx 0.
- halted held high in DONE for 20 cycles: done stays 1 and no re-trigger occurs until halted goes low, then high.
